lan_from_nb_arbiter: RTL and testbench

//  Shares the single from_nb switch input between two AXIS packet sources:
//  s0 = LAN local formatter output (locally generated control messages),
//  s1 = network-bridge receive path. Packet-locked round-robin arbitration.
//  A per-source enable mask is provided. The output is registered through a
//  2-entry skid buffer. Per-source packet counters support the control API.

---
 rtl/ctrl_api_pkg.sv | 21 ++
 rtl/lan_from_nb_arbiter_if.sv | 35 +++
 rtl/axis_skid_buffer.sv | 70 +++++++
 rtl/lan_from_nb_arbiter.sv | 128 ++++++++++++
 tb/tb_lan_from_nb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_api_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_api_pkg
//   Shared definitions for the LAN control path: AXIS width constants used by
//   lan_local_formatter, lan_from_nb_arbiter and the from_nb switch, plus the
//   arbiter state encoding.
// ---------------------------------------------------------------------------
package ctrl_api_pkg;

    localparam int unsigned AXIS_DATA_W  = 64;
    localparam int unsigned AXIS_KEEP_W  = AXIS_DATA_W / 8;
    localparam int unsigned AXIS_TDEST_W = 8;
    localparam int unsigned AXIS_TUSER_W = 64;   // {dst port, src port, IP}
    localparam int unsigned PKT_CNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lan_from_nb_arbiter_if.sv
// ---------------------------------------------------------------------------
// lan_from_nb_arbiter_if
//   One AXIS stream (tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast).
//   master : drives the beat fields and tvalid, receives tready
//   slave  : receives the beat fields and tvalid, drives tready
// ---------------------------------------------------------------------------
interface lan_from_nb_arbiter_if
    import ctrl_api_pkg::*;
#(
    parameter int unsigned DATA_W  = AXIS_DATA_W,
    parameter int unsigned KEEP_W  = AXIS_KEEP_W,
    parameter int unsigned TDEST_W = AXIS_TDEST_W,
    parameter int unsigned TUSER_W = AXIS_TUSER_W
) ();

    logic               tvalid;
    logic               tready;
    logic [DATA_W-1:0]  tdata;
    logic [KEEP_W-1:0]  tkeep;
    logic [TDEST_W-1:0] tid;
    logic [TDEST_W-1:0] tdest;
    logic [TUSER_W-1:0] tuser;
    logic               tlast;

    modport master (
        output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        output tready
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
//   2-entry output register stage for a packed AXIS beat. Accepted beats
//   appear on o_valid one cycle later; full throughput while i_ready=1.
//   o_ready comes from a flop, so it never depends on i_ready combinationally.
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_valid/o_ready     upstream handshake, i_beat upstream beat
//   o_valid/i_ready     downstream handshake, o_beat downstream beat
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int unsigned BEAT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [BEAT_W-1:0] i_beat,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BEAT_W-1:0] o_beat
);

    logic [BEAT_W-1:0] ent0_q, ent0_d;
    logic [BEAT_W-1:0] ent1_q, ent1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              push, pop;

    assign o_ready = ~full_q;
    assign o_valid = (cnt_q != 2'd0);
    // The read slot is untouched until popped, so o_beat holds while stalled.
    assign o_beat  = rd_ptr_q ? ent1_q : ent0_q;
    assign push    = i_valid & ~full_q;
    assign pop     = o_valid & i_ready;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (push) begin
            if (wr_ptr_q) ent1_d = i_beat;
            else          ent0_d = i_beat;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        full_d   = (cnt_d == 2'd2);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

endmodule

// File: rtl/lan_from_nb_arbiter.sv
// ---------------------------------------------------------------------------
// lan_from_nb_arbiter
//   Packet-locked round-robin arbiter sharing the from_nb switch input
//   between s0 (LAN local formatter) and s1 (network-bridge receive path).
//   Output is registered through a 2-entry skid buffer.
// Ports
//   i_clk, i_ap_rst_n   clock, async active-low reset
//   i_src_enable[1:0]   bit n=1: source n may win arbitration (sampled in IDLE)
//   s0, s1              AXIS slave inputs
//   m                   AXIS master output to the from_nb switch
//   o_grant[1:0]        one-hot locked source, 0 when idle
//   o_pkt_cnt0/1        packets forwarded per source (wrapping)
// ---------------------------------------------------------------------------
module lan_from_nb_arbiter
    import ctrl_api_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH          = ctrl_api_pkg::AXIS_DATA_W,
    parameter int unsigned AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
    parameter int unsigned AXIS_FROM_NB_TDEST_WIDTH = ctrl_api_pkg::AXIS_TDEST_W,
    parameter int unsigned AXIS_FROM_NB_TUSER_WIDTH = ctrl_api_pkg::AXIS_TUSER_W,
    parameter int unsigned PKT_CNT_WIDTH            = ctrl_api_pkg::PKT_CNT_W
) (
    input  logic                     i_clk,
    input  logic                     i_ap_rst_n,
    input  logic [1:0]               i_src_enable,
    lan_from_nb_arbiter_if.slave     s0,
    lan_from_nb_arbiter_if.slave     s1,
    lan_from_nb_arbiter_if.master    m,
    output logic [1:0]               o_grant,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt0,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt1
);

    localparam int unsigned BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH
                                   + 2 * AXIS_FROM_NB_TDEST_WIDTH
                                   + AXIS_FROM_NB_TUSER_WIDTH + 1;
    localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

    arb_state_t               state_q, state_d;
    logic                     last_served_q, last_served_d;  // 1: s1 served last
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

    logic              elig0, elig1;
    logic              s0_ready_c, s1_ready_c;
    logic              sk_in_valid, sk_in_ready, sk_out_valid;
    logic [BEAT_W-1:0] beat0, beat1, sk_in_beat, sk_out_beat;

    assign beat0 = {s0.tdata, s0.tkeep, s0.tid, s0.tdest, s0.tuser, s0.tlast};
    assign beat1 = {s1.tdata, s1.tkeep, s1.tid, s1.tdest, s1.tuser, s1.tlast};
    assign elig0 = s0.tvalid & i_src_enable[0];
    assign elig1 = s1.tvalid & i_src_enable[1];

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        pkt_cnt0_d    = pkt_cnt0_q;
        pkt_cnt1_d    = pkt_cnt1_q;
        s0_ready_c    = 1'b0;
        s1_ready_c    = 1'b0;
        sk_in_valid   = 1'b0;
        sk_in_beat    = beat0;
        case (state_q)
            IDLE: begin
                if (elig0 && elig1) state_d = last_served_q ? LOCK0 : LOCK1;
                else if (elig0)     state_d = LOCK0;
                else if (elig1)     state_d = LOCK1;
            end
            LOCK0: begin
                s0_ready_c  = sk_in_ready;
                sk_in_valid = s0.tvalid;
                sk_in_beat  = beat0;
                if (s0.tvalid && sk_in_ready && s0.tlast) begin
                    state_d       = IDLE;
                    last_served_d = 1'b0;
                    pkt_cnt0_d    = pkt_cnt0_q + CNT_ONE;
                end
            end
            LOCK1: begin
                s1_ready_c  = sk_in_ready;
                sk_in_valid = s1.tvalid;
                sk_in_beat  = beat1;
                if (s1.tvalid && sk_in_ready && s1.tlast) begin
                    state_d       = IDLE;
                    last_served_d = 1'b1;
                    pkt_cnt1_d    = pkt_cnt1_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            pkt_cnt0_q    <= '0;
            pkt_cnt1_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            pkt_cnt0_q    <= pkt_cnt0_d;
            pkt_cnt1_q    <= pkt_cnt1_d;
        end
    end

    axis_skid_buffer #(
        .BEAT_W (BEAT_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_ap_rst_n),
        .i_valid (sk_in_valid),
        .o_ready (sk_in_ready),
        .i_beat  (sk_in_beat),
        .o_valid (sk_out_valid),
        .i_ready (m.tready),
        .o_beat  (sk_out_beat)
    );

    assign s0.tready  = s0_ready_c;
    assign s1.tready  = s1_ready_c;
    assign m.tvalid   = sk_out_valid;
    assign {m.tdata, m.tkeep, m.tid, m.tdest, m.tuser, m.tlast} = sk_out_beat;
    assign o_grant    = {state_q == LOCK1, state_q == LOCK0};
    assign o_pkt_cnt0 = pkt_cnt0_q;
    assign o_pkt_cnt1 = pkt_cnt1_q;

endmodule

// File: tb/tb_lan_from_nb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lan_from_nb_arbiter
//   Directed bench for lan_from_nb_arbiter. Beat n of a packet with base B
//   carries tdata = B*(n+1), tuser = ~tdata, tid = source, tdest = 0xA0|source.
//   Counters are narrowed to 4 bits so the wrap is reachable with traffic.
// ---------------------------------------------------------------------------
module tb_lan_from_nb_arbiter;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    en = 2'b11;
    logic [1:0]    grant;
    logic [CW-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] out_data[$];
    logic        out_last[$];
    logic [7:0]  out_id[$];
    logic [7:0]  out_dest[$];
    logic [63:0] out_user[$];
    int          out_cyc[$];

    lan_from_nb_arbiter_if s0_if ();
    lan_from_nb_arbiter_if s1_if ();
    lan_from_nb_arbiter_if m_if ();

    lan_from_nb_arbiter #(
        .PKT_CNT_WIDTH (CW)
    ) dut (
        .i_clk        (clk),
        .i_ap_rst_n   (rst_n),
        .i_src_enable (en),
        .s0           (s0_if),
        .s1           (s1_if),
        .m            (m_if),
        .o_grant      (grant),
        .o_pkt_cnt0   (cnt0),
        .o_pkt_cnt1   (cnt1)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [63:0] base, input int b, input int n);
        logic [63:0] d;
        d = base * 64'(b + 1);
        if (src == 0) begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tkeep = 8'hFF; s0_if.tid = 8'h00;
            s0_if.tdest = 8'hA0; s0_if.tuser = ~d; s0_if.tlast = (b == n - 1);
        end else begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tkeep = 8'hFF; s1_if.tid = 8'h01;
            s1_if.tdest = 8'hA1; s1_if.tuser = ~d; s1_if.tlast = (b == n - 1);
        end
    endtask

    function automatic logic src_ready(input int src);
        return (src == 0) ? s0_if.tready : s1_if.tready;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the last beat.
    task automatic send_pkt(input int src, input int n, input logic [63:0] base);
        int b = 0;
        int stall = 0;
        drive(src, 1'b1, base, 0, n);
        while (b < n) begin
            @(negedge clk);
            if (src_ready(src)) begin
                @(posedge clk); #1;
                b++;
                stall = 0;
                if (b < n) drive(src, 1'b1, base, b, n);
                else       drive(src, 1'b0, base, 0, n);
            end else begin
                stall++;
                if (stall > 200) begin
                    expect_eq("send_timeout", 64'(stall), 64'd200);
                    drive(src, 1'b0, base, 0, n);
                    b = n;
                end
            end
        end
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (out_data.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        expect_eq("beats_received", 64'(out_data.size()), 64'(n));
    endtask

    task automatic clear_out();
        out_data.delete(); out_last.delete(); out_id.delete();
        out_dest.delete(); out_user.delete(); out_cyc.delete();
    endtask

    task automatic check_pkt(input string tag, input int first, input int n, input logic [63:0] base, input int src);
        for (int b = 0; b < n; b++) begin
            if (first + b < out_data.size()) begin
                expect_eq({tag, "_data"}, out_data[first+b], base * 64'(b + 1));
                expect_eq({tag, "_last"}, 64'(out_last[first+b]), 64'(b == n - 1));
                expect_eq({tag, "_id"}, 64'(out_id[first+b]), 64'(src));
            end
        end
    endtask

    // Output monitor and hold-while-stalled check.
    logic        stalled_prev = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        cyc++;
        if (rst_n && stalled_prev) begin
            expect_eq("stall_valid", 64'(m_if.tvalid), 64'd1);
            expect_eq("stall_data", m_if.tdata, prev_data);
            expect_eq("stall_last", 64'(m_if.tlast), 64'(prev_last));
        end
        stalled_prev = rst_n && m_if.tvalid && !m_if.tready;
        prev_data    = m_if.tdata;
        prev_last    = m_if.tlast;
        if (rst_n && m_if.tvalid && m_if.tready) begin
            out_data.push_back(m_if.tdata);
            out_last.push_back(m_if.tlast);
            out_id.push_back(m_if.tid);
            out_dest.push_back(m_if.tdest);
            out_user.push_back(m_if.tuser);
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] bases[4];
        drive(0, 1'b0, 64'd0, 0, 1);
        drive(1, 1'b0, 64'd0, 0, 1);
        m_if.tready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        expect_eq("rst_s0_ready", 64'(s0_if.tready), 64'd0);
        expect_eq("rst_s1_ready", 64'(s1_if.tready), 64'd0);
        expect_eq("rst_grant", 64'(grant), 64'd0);
        expect_eq("rst_cnt0", 64'(cnt0), 64'd0);
        expect_eq("rst_cnt1", 64'(cnt1), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single s0 packet, latency
        clear_out();
        fork
            send_pkt(0, 3, 64'h11);
            begin
                @(negedge clk);
                expect_eq("t1_grant_c0", 64'(grant), 64'd0);
                expect_eq("t1_mvalid_c0", 64'(m_if.tvalid), 64'd0);
                @(negedge clk);
                expect_eq("t1_grant_c1", 64'(grant), 64'd1);
                expect_eq("t1_ready_c1", 64'(s0_if.tready), 64'd1);
                expect_eq("t1_mvalid_c1", 64'(m_if.tvalid), 64'd0);
                @(negedge clk);
                expect_eq("t1_mvalid_c2", 64'(m_if.tvalid), 64'd1);
                expect_eq("t1_mdata_c2", m_if.tdata, 64'h11);
            end
        join
        wait_beats(3);
        check_pkt("t1", 0, 3, 64'h11, 0);
        for (int i = 0; i < out_data.size(); i++) begin
            expect_eq("t1_dest", 64'(out_dest[i]), 64'hA0);
            expect_eq("t1_user", out_user[i], ~out_data[i]);
        end
        expect_eq("t1_cnt0", 64'(cnt0), 64'd1);
        expect_eq("t1_cnt1", 64'(cnt1), 64'd0);

        // 2: both sources contending, round-robin with one idle cycle between packets
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        clear_out();
        bases[0] = 64'h101; bases[1] = 64'h1001; bases[2] = 64'h10001; bases[3] = 64'h100001;
        fork
            begin send_pkt(0, 4, bases[0]); send_pkt(0, 4, bases[2]); end
            begin send_pkt(1, 4, bases[1]); send_pkt(1, 4, bases[3]); end
        join
        wait_beats(16);
        for (int p = 0; p < 4; p++) check_pkt("t2", p * 4, 4, bases[p], p % 2);
        for (int i = 1; i < out_cyc.size(); i++)
            expect_eq("t2_gap", 64'(out_cyc[i] - out_cyc[i-1]), (i % 4 == 0) ? 64'd2 : 64'd1);
        expect_eq("t2_cnt0", 64'(cnt0), 64'd2);
        expect_eq("t2_cnt1", 64'(cnt1), 64'd2);

        // 3: m_tready pattern 1,0,0,1 during a 5-beat packet
        clear_out();
        fork
            send_pkt(0, 5, 64'h31);
            begin
                logic [3:0] pat;
                pat = 4'b1001;
                for (int k = 0; k < 24; k++) begin
                    m_if.tready = pat[k % 4];
                    @(posedge clk); #1;
                end
                m_if.tready = 1'b1;
            end
        join
        wait_beats(5);
        expect_eq("t3_no_dup", 64'(out_data.size()), 64'd5);
        check_pkt("t3", 0, 5, 64'h31, 0);
        expect_eq("t3_cnt0", 64'(cnt0), 64'd3);

        // 4: disable s1 mid-packet, then re-enable
        clear_out();
        fork
            send_pkt(1, 4, 64'h4001);
            begin : clr_en
                int k = 0;
                while (grant != 2'b10 && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                expect_eq("t4_locked", 64'(grant), 64'd2);
                @(posedge clk); #1;
                en = 2'b01;
            end
        join
        wait_beats(4);
        check_pkt("t4a", 0, 4, 64'h4001, 1);
        clear_out();
        fork
            send_pkt(1, 2, 64'h5001);
            begin
                repeat (4) begin
                    @(negedge clk);
                    expect_eq("t4_no_grant", 64'(grant), 64'd0);
                    expect_eq("t4_s1_ready", 64'(s1_if.tready), 64'd0);
                end
                @(posedge clk); #1;
                en = 2'b11;
            end
        join
        wait_beats(2);
        check_pkt("t4b", 0, 2, 64'h5001, 1);
        expect_eq("t4_cnt1", 64'(cnt1), 64'd4);
        expect_eq("t4_cnt0", 64'(cnt0), 64'd3);

        // 5: asynchronous reset on beat 2 of 4
        drive(1, 1'b1, 64'h6001, 0, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1, 1'b1, 64'h6001, 1, 4);
        @(posedge clk); #1;
        drive(1, 1'b1, 64'h6001, 2, 4);
        expect_eq("t5_pre_grant", 64'(grant), 64'd2);
        expect_eq("t5_pre_mvalid", 64'(m_if.tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        expect_eq("t5_mvalid", 64'(m_if.tvalid), 64'd0);
        expect_eq("t5_s1_ready", 64'(s1_if.tready), 64'd0);
        expect_eq("t5_grant", 64'(grant), 64'd0);
        expect_eq("t5_cnt0", 64'(cnt0), 64'd0);
        expect_eq("t5_cnt1", 64'(cnt1), 64'd0);
        drive(1, 1'b0, 64'd0, 0, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        clear_out();
        send_pkt(1, 3, 64'h777);
        wait_beats(3);
        check_pkt("t5", 0, 3, 64'h777, 1);
        expect_eq("t5_cnt1_after", 64'(cnt1), 64'd1);

        // 6: counter wrap with single-beat packets
        for (int i = 0; i < 14; i++) send_pkt(1, 1, 64'h900 + 64'(i));
        repeat (2) @(negedge clk);
        expect_eq("t6_cnt1_max", 64'(cnt1), 64'hF);
        clear_out();
        send_pkt(1, 1, 64'hABC);
        wait_beats(1);
        check_pkt("t6", 0, 1, 64'hABC, 1);
        repeat (2) @(negedge clk);
        expect_eq("t6_cnt1_wrap", 64'(cnt1), 64'd0);
        expect_eq("t6_cnt0", 64'(cnt0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
